// File: rtl/hcordic_result_fsl_master.sv
// hcordic_result_fsl_master: buffers HCORDIC result packets and serializes them as tag/x/y/z words onto an FSL master port
module hcordic_result_fsl_master #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [103:0]      ResultPacket,
    input  logic              ResultValid,
    input  logic              FSL_M_Full,
    output logic [31:0]       FSL_M_Data,
    output logic              FSL_M_Control,
    output logic              FSL_M_Write,
    output logic [ADDR_W:0]   Occupancy,
    output logic              Busy,
    output logic              Overflow
);
    typedef enum logic [2:0] {IDLE, HDR, WX, WY, WZ} state_t;

    state_t            state, state_nx;
    logic [103:0]      mem [DEPTH];
    logic [103:0]      hold;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic              pop, push;

    assign FSL_M_Write = state != IDLE && !FSL_M_Full;
    assign pop         = count != '0 && (state == IDLE || (state == WZ && FSL_M_Write));
    assign push        = ResultValid && (count != (ADDR_W+1)'(DEPTH) || pop);
    assign Occupancy   = count;
    assign Busy        = state != IDLE;

    // Word mux and next-state: each word is held until the FSL side accepts it
    always_comb begin
        FSL_M_Control = state == HDR;
        FSL_M_Data    = state == HDR ? {24'h000000, hold[103:96]} :
                        state == WX  ? hold[31:0] :
                        state == WY  ? hold[63:32] :
                        state == WZ  ? hold[95:64] : '0;
        state_nx      = state;
        case (state)
            HDR:     state_nx = FSL_M_Write ? WX : HDR;
            WX:      state_nx = FSL_M_Write ? WY : WX;
            WY:      state_nx = FSL_M_Write ? WZ : WY;
            WZ:      state_nx = !FSL_M_Write ? WZ : count != '0 ? HDR : IDLE;
            default: state_nx = count != '0 ? HDR : IDLE;
        endcase
    end

    // Packet storage; write during a full-with-pop cycle reads the old head first
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= ResultPacket;
    end

    // Pointers, occupancy, holding register, sticky overflow and FSM state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            hold     <= '0;
            Overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            count    <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
            Overflow <= Overflow | (ResultValid & ~push);
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
                hold   <= mem[rd_ptr];
            end
        end
    end
endmodule
